// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - FIR MAC control sequencer: buffer/coef addressing, interleaved accumulate, partial-sum reduce
module fir_mac_sequencer #(
  parameter int TAPS    = 64,
  parameter int AW      = 6,
  parameter int MUL_LAT = 4,
  parameter int ALU_LAT = 5,
  parameter int PW      = 3
) (
  input  logic          clk_fast,
  input  logic          rst_n,
  input  logic          valid_in_i,
  output logic          in_ready_o,
  output logic          sample_drop_o,
  input  logic          cload_i,
  input  logic [AW-1:0] caddr_i,
  output logic          cload_err_o,
  output logic          cmem_we_o,
  output logic [AW-1:0] cmem_addr_o,
  output logic          dmem_wr_o,
  output logic [AW-1:0] dmem_addr_o,
  output logic          mul_issue_o,
  output logic          add_issue_o,
  output logic [1:0]    add_a_sel_o,
  output logic [1:0]    add_b_sel_o,
  output logic          add_norm_o,
  output logic          preg_wr_o,
  output logic [PW-1:0] preg_waddr_o,
  output logic [PW-1:0] preg_raddr_o,
  output logic          dout_valid_o,
  output logic          busy_o
);
  localparam int MAC_LEN = TAPS + MUL_LAT;
  localparam int RED_LEN = (ALU_LAT - 1) * ALU_LAT;
  localparam int CNT_MAX = (MAC_LEN > RED_LEN) ? MAC_LEN : RED_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_TAPS      = CW'(TAPS);
  localparam logic [CW-1:0] C_MAC_END   = CW'(MAC_LEN - 1);
  localparam logic [CW-1:0] C_DRAIN_END = CW'(ALU_LAT - 1);
  localparam logic [CW-1:0] C_RED_END   = CW'(RED_LEN - 1);
  localparam logic [CW-1:0] C_MUL       = CW'(MUL_LAT);
  localparam logic [CW-1:0] C_BSEL      = CW'(MUL_LAT + ALU_LAT);
  localparam logic [CW-1:0] C_ALU       = CW'(ALU_LAT);
  localparam logic [CW-1:0] C_LAST_I    = CW'(ALU_LAT - 2);
  localparam logic [AW-1:0] A_LAST      = AW'(TAPS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_DRAIN, S_REDUCE, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] dptr_q, dptr_d;
  logic [CW-1:0] red_idx, red_ph;

  logic          mul_issue_q, mul_issue_d, add_issue_q, add_issue_d;
  logic [1:0]    add_a_sel_q, add_a_sel_d, add_b_sel_q, add_b_sel_d;
  logic          add_norm_q, add_norm_d, preg_wr_q, preg_wr_d;
  logic [PW-1:0] preg_waddr_q, preg_waddr_d, preg_raddr_q, preg_raddr_d;
  logic          dmem_wr_q, dmem_wr_d, dout_valid_q, dout_valid_d;
  logic [AW-1:0] dmem_addr_q, dmem_addr_d, cmem_addr_q, cmem_addr_d;
  logic          idle;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    wptr_d  = wptr_q;
    dptr_d  = dptr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (valid_in_i) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_MAC;
        cnt_d   = '0;
        wptr_d  = (wptr_q == A_LAST) ? '0 : wptr_q + AW'(1);
        dptr_d  = wptr_q;
      end
      S_MAC: begin
        // walk backwards from the newest sample, wrapping inside TAPS
        dptr_d = (dptr_q == '0) ? A_LAST : dptr_q - AW'(1);
        if (cnt_q == C_MAC_END) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        if (cnt_q == C_DRAIN_END) begin
          state_d = S_REDUCE;
          cnt_d   = '0;
        end
      end
      S_REDUCE: begin
        if (cnt_q == C_RED_END) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign red_idx = cnt_d / C_ALU;
  assign red_ph  = cnt_d % C_ALU;

  // Outputs are decoded from the next state so the registers line up with state_q.
  always_comb begin
    mul_issue_d  = 1'b0;
    add_issue_d  = 1'b0;
    add_a_sel_d  = 2'd0;
    add_b_sel_d  = 2'd0;
    add_norm_d   = 1'b0;
    preg_wr_d    = 1'b0;
    preg_waddr_d = '0;
    preg_raddr_d = '0;
    dmem_wr_d    = 1'b0;
    dmem_addr_d  = '0;
    cmem_addr_d  = '0;
    dout_valid_d = 1'b0;
    case (state_d)
      S_LOAD: begin
        dmem_wr_d   = 1'b1;
        dmem_addr_d = wptr_q;
      end
      S_MAC: begin
        if (cnt_d < C_TAPS) begin
          mul_issue_d = 1'b1;
          cmem_addr_d = AW'(cnt_d);
          dmem_addr_d = dptr_d;
        end
        if (cnt_d >= C_MUL) begin
          add_issue_d = 1'b1;
          add_b_sel_d = (cnt_d >= C_BSEL) ? 2'd1 : 2'd0;
        end
      end
      S_DRAIN: begin
        preg_wr_d    = 1'b1;
        preg_waddr_d = PW'(cnt_d);
      end
      S_REDUCE: begin
        if (red_ph == '0) begin
          add_issue_d  = 1'b1;
          add_b_sel_d  = 2'd2;
          add_a_sel_d  = (red_idx == '0) ? 2'd2 : 2'd1;
          preg_raddr_d = PW'(red_idx + CW'(1));
          add_norm_d   = (red_idx == C_LAST_I);
        end
      end
      S_DONE: dout_valid_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wptr_q       <= '0;
      dptr_q       <= '0;
      mul_issue_q  <= 1'b0;
      add_issue_q  <= 1'b0;
      add_a_sel_q  <= 2'd0;
      add_b_sel_q  <= 2'd0;
      add_norm_q   <= 1'b0;
      preg_wr_q    <= 1'b0;
      preg_waddr_q <= '0;
      preg_raddr_q <= '0;
      dmem_wr_q    <= 1'b0;
      dmem_addr_q  <= '0;
      cmem_addr_q  <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      dptr_q       <= dptr_d;
      mul_issue_q  <= mul_issue_d;
      add_issue_q  <= add_issue_d;
      add_a_sel_q  <= add_a_sel_d;
      add_b_sel_q  <= add_b_sel_d;
      add_norm_q   <= add_norm_d;
      preg_wr_q    <= preg_wr_d;
      preg_waddr_q <= preg_waddr_d;
      preg_raddr_q <= preg_raddr_d;
      dmem_wr_q    <= dmem_wr_d;
      dmem_addr_q  <= dmem_addr_d;
      cmem_addr_q  <= cmem_addr_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  // Coefficient writes and error pulses respond in the same cycle as the request.
  assign idle          = (state_q == S_IDLE);
  assign in_ready_o    = idle;
  assign busy_o        = ~idle;
  assign sample_drop_o = valid_in_i & ~idle;
  assign cload_err_o   = cload_i & ~idle;
  assign cmem_we_o     = cload_i & idle;
  assign cmem_addr_o   = (cload_i & idle) ? caddr_i : cmem_addr_q;
  assign dmem_wr_o     = dmem_wr_q;
  assign dmem_addr_o   = dmem_addr_q;
  assign mul_issue_o   = mul_issue_q;
  assign add_issue_o   = add_issue_q;
  assign add_a_sel_o   = add_a_sel_q;
  assign add_b_sel_o   = add_b_sel_q;
  assign add_norm_o    = add_norm_q;
  assign preg_wr_o     = preg_wr_q;
  assign preg_waddr_o  = preg_waddr_q;
  assign preg_raddr_o  = preg_raddr_q;
  assign dout_valid_o  = dout_valid_q;
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb/tb_fir_mac_sequencer.sv - directed table-driven bench for fir_mac_sequencer (default and small configs)
module tb_fir_mac_sequencer;
  logic clk_fast = 1'b0;
  logic rst_n;
  logic valid_in, cload;
  logic [5:0] caddr;

  logic in_ready1, sdrop1, cerr1, cwe1, dwr1, mul1, add1, norm1, pwr1, dout1, busy1;
  logic [1:0] asel1, bsel1;
  logic [5:0] caddr1, daddr1;
  logic [2:0] pwa1, pra1;
  logic in_ready2, sdrop2, cerr2, cwe2, dwr2, mul2, add2, norm2, pwr2, dout2, busy2;
  logic [1:0] asel2, bsel2;
  logic [5:0] caddr2, daddr2;
  logic [2:0] pwa2, pra2;

  always #5 clk_fast = ~clk_fast;

  fir_mac_sequencer dut1 (
    .clk_fast(clk_fast), .rst_n(rst_n), .valid_in_i(valid_in), .in_ready_o(in_ready1),
    .sample_drop_o(sdrop1), .cload_i(cload), .caddr_i(caddr), .cload_err_o(cerr1),
    .cmem_we_o(cwe1), .cmem_addr_o(caddr1), .dmem_wr_o(dwr1), .dmem_addr_o(daddr1),
    .mul_issue_o(mul1), .add_issue_o(add1), .add_a_sel_o(asel1), .add_b_sel_o(bsel1),
    .add_norm_o(norm1), .preg_wr_o(pwr1), .preg_waddr_o(pwa1), .preg_raddr_o(pra1),
    .dout_valid_o(dout1), .busy_o(busy1));

  fir_mac_sequencer #(.TAPS(8), .AW(6), .MUL_LAT(2), .ALU_LAT(3), .PW(3)) dut2 (
    .clk_fast(clk_fast), .rst_n(rst_n), .valid_in_i(valid_in), .in_ready_o(in_ready2),
    .sample_drop_o(sdrop2), .cload_i(cload), .caddr_i(caddr), .cload_err_o(cerr2),
    .cmem_we_o(cwe2), .cmem_addr_o(caddr2), .dmem_wr_o(dwr2), .dmem_addr_o(daddr2),
    .mul_issue_o(mul2), .add_issue_o(add2), .add_a_sel_o(asel2), .add_b_sel_o(bsel2),
    .add_norm_o(norm2), .preg_wr_o(pwr2), .preg_waddr_o(pwa2), .preg_raddr_o(pra2),
    .dout_valid_o(dout2), .busy_o(busy2));

  typedef struct packed {
    logic in_ready, busy, sdrop, cerr, cwe, dwr, mul, add, norm, pwr, dout;
    logic [1:0] asel, bsel;
    logic [5:0] caddr, daddr;
    logic [2:0] pwa, pra;
  } obs_t;

  typedef struct {
    int dut, off;
    logic dwr, mul, add;
    logic [1:0] asel, bsel;
    logic pwr, norm, dout;
    int daddr, caddr, pwa, pra;
  } vec_t;

  obs_t cap1 [0:127];
  obs_t cap2 [0:127];
  vec_t vecs [$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample(input int j);
    cap1[j] = {in_ready1, busy1, sdrop1, cerr1, cwe1, dwr1, mul1, add1, norm1, pwr1, dout1,
               asel1, bsel1, caddr1, daddr1, pwa1, pra1};
    cap2[j] = {in_ready2, busy2, sdrop2, cerr2, cwe2, dwr2, mul2, add2, norm2, pwr2, dout2,
               asel2, bsel2, caddr2, daddr2, pwa2, pra2};
  endtask

  // Offset 0 is the cycle valid_in is presented; offset j is j cycles later.
  task automatic capture(input int len, input int inj_v, input int inj_c, input int inj_r, input logic cl0);
    @(negedge clk_fast);
    valid_in = 1'b1; cload = cl0; caddr = 6'd17;
    #1 sample(0);
    for (int j = 1; j <= len; j++) begin
      @(negedge clk_fast);
      valid_in = (j == inj_v);
      cload    = (j == inj_c);
      caddr    = 6'd5;
      if (inj_r > 0) rst_n = !(j >= inj_r && j < inj_r + 2);
      #1 sample(j);
    end
    valid_in = 1'b0; cload = 1'b0;
  endtask

  function automatic int cnt(input int dut, input int f, input int lo, input int hi);
    obs_t o;
    int n = 0;
    for (int j = lo; j <= hi; j++) begin
      o = (dut == 1) ? cap1[j] : cap2[j];
      case (f)
        0: n += int'(o.mul);
        1: n += int'(o.add);
        2: n += int'(o.pwr);
        3: n += int'(o.norm);
        4: n += int'(o.dout);
        5: n += int'(o.sdrop);
        6: n += int'(o.cerr);
        default: n += int'(o.cwe);
      endcase
    end
    return n;
  endfunction

  function automatic logic [63:0] pack_act(input obs_t o);
    return 64'({o.dwr, o.mul, o.add, o.asel, o.bsel, o.pwr, o.norm, o.dout, o.daddr, o.caddr, o.pwa, o.pra});
  endfunction

  function automatic logic [63:0] pack_exp(input vec_t v);
    return 64'({v.dwr, v.mul, v.add, v.asel, v.bsel, v.pwr, v.norm, v.dout,
                6'(v.daddr), 6'(v.caddr), 3'(v.pwa), 3'(v.pra)});
  endfunction

  initial begin
    obs_t idle_exp;
    obs_t o;
    idle_exp = '0;
    idle_exp.in_ready = 1'b1;

    // dut, off, dwr, mul, add, asel, bsel, pwr, norm, dout, daddr, caddr, pwa, pra
    vecs.push_back('{1,  1, 1,0,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{1,  2, 0,1,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{1,  3, 0,1,0, 2'd0,2'd0, 0,0,0, 63, 1,0,0});
    vecs.push_back('{1,  5, 0,1,0, 2'd0,2'd0, 0,0,0, 61, 3,0,0});
    vecs.push_back('{1,  6, 0,1,1, 2'd0,2'd0, 0,0,0, 60, 4,0,0});
    vecs.push_back('{1, 10, 0,1,1, 2'd0,2'd0, 0,0,0, 56, 8,0,0});
    vecs.push_back('{1, 11, 0,1,1, 2'd0,2'd1, 0,0,0, 55, 9,0,0});
    vecs.push_back('{1, 65, 0,1,1, 2'd0,2'd1, 0,0,0,  1,63,0,0});
    vecs.push_back('{1, 66, 0,0,1, 2'd0,2'd1, 0,0,0,  0, 0,0,0});
    vecs.push_back('{1, 69, 0,0,1, 2'd0,2'd1, 0,0,0,  0, 0,0,0});
    vecs.push_back('{1, 70, 0,0,0, 2'd0,2'd0, 1,0,0,  0, 0,0,0});
    vecs.push_back('{1, 74, 0,0,0, 2'd0,2'd0, 1,0,0,  0, 0,4,0});
    vecs.push_back('{1, 75, 0,0,1, 2'd2,2'd2, 0,0,0,  0, 0,0,1});
    vecs.push_back('{1, 76, 0,0,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{1, 80, 0,0,1, 2'd1,2'd2, 0,0,0,  0, 0,0,2});
    vecs.push_back('{1, 85, 0,0,1, 2'd1,2'd2, 0,0,0,  0, 0,0,3});
    vecs.push_back('{1, 90, 0,0,1, 2'd1,2'd2, 0,1,0,  0, 0,0,4});
    vecs.push_back('{1, 94, 0,0,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{1, 95, 0,0,0, 2'd0,2'd0, 0,0,1,  0, 0,0,0});
    vecs.push_back('{1, 96, 0,0,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{2,  1, 1,0,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{2,  2, 0,1,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{2,  3, 0,1,0, 2'd0,2'd0, 0,0,0,  7, 1,0,0});
    vecs.push_back('{2,  4, 0,1,1, 2'd0,2'd0, 0,0,0,  6, 2,0,0});
    vecs.push_back('{2,  7, 0,1,1, 2'd0,2'd1, 0,0,0,  3, 5,0,0});
    vecs.push_back('{2,  9, 0,1,1, 2'd0,2'd1, 0,0,0,  1, 7,0,0});
    vecs.push_back('{2, 11, 0,0,1, 2'd0,2'd1, 0,0,0,  0, 0,0,0});
    vecs.push_back('{2, 12, 0,0,0, 2'd0,2'd0, 1,0,0,  0, 0,0,0});
    vecs.push_back('{2, 14, 0,0,0, 2'd0,2'd0, 1,0,0,  0, 0,2,0});
    vecs.push_back('{2, 15, 0,0,1, 2'd2,2'd2, 0,0,0,  0, 0,0,1});
    vecs.push_back('{2, 16, 0,0,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});
    vecs.push_back('{2, 18, 0,0,1, 2'd1,2'd2, 0,1,0,  0, 0,0,2});
    vecs.push_back('{2, 21, 0,0,0, 2'd0,2'd0, 0,0,1,  0, 0,0,0});
    vecs.push_back('{2, 22, 0,0,0, 2'd0,2'd0, 0,0,0,  0, 0,0,0});

    rst_n = 1'b0; valid_in = 1'b0; cload = 1'b0; caddr = '0;
    repeat (2) @(negedge clk_fast);
    #1 sample(0);
    chk("in_reset_idle1", 64'(cap1[0]), 64'(idle_exp));
    @(negedge clk_fast);
    rst_n = 1'b1;

    // Idle window
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_fast);
      #1 sample(0);
      chk("idle_window1", 64'(cap1[0]), 64'(idle_exp));
    end
    chk("idle_window2", 64'(cap2[0]), 64'(idle_exp));

    // Reset mid-MAC aborts without dout
    capture(100, -1, -1, 20, 1'b0);
    chk("busy_mid_mac", 64'({cap1[10].busy, cap1[10].in_ready}), 64'(2'b10));
    chk("abort_no_dout1", 64'(cnt(1, 4, 1, 100)), 64'(0));
    chk("abort_no_dout2", 64'(cnt(2, 4, 1, 100)), 64'(0));
    chk("after_abort_idle", 64'(cap1[23]), 64'(idle_exp));

    // Clean run: table of cycle-exact vectors for both configurations
    capture(100, -1, -1, -1, 1'b0);
    foreach (vecs[i]) begin
      o = (vecs[i].dut == 1) ? cap1[vecs[i].off] : cap2[vecs[i].off];
      chk($sformatf("vec_dut%0d_off%0d", vecs[i].dut, vecs[i].off), pack_act(o), pack_exp(vecs[i]));
    end
    chk("mul_count1",  64'(cnt(1, 0, 1, 100)), 64'(64));
    chk("add_count1",  64'(cnt(1, 1, 1, 100)), 64'(68));
    chk("pwr_count1",  64'(cnt(1, 2, 1, 100)), 64'(5));
    chk("norm_count1", 64'(cnt(1, 3, 1, 100)), 64'(1));
    chk("dout_count1", 64'(cnt(1, 4, 1, 100)), 64'(1));
    chk("mul_count2",  64'(cnt(2, 0, 1, 100)), 64'(8));
    chk("add_count2",  64'(cnt(2, 1, 1, 100)), 64'(10));
    chk("pwr_count2",  64'(cnt(2, 2, 1, 100)), 64'(3));
    chk("dout_count2", 64'(cnt(2, 4, 1, 100)), 64'(1));

    // Write pointer wrap over 65 consecutive samples
    @(negedge clk_fast); rst_n = 1'b0;
    @(negedge clk_fast); rst_n = 1'b1;
    for (int s = 1; s <= 65; s++) begin
      capture(97, -1, -1, -1, 1'b0);
      if (s == 64) chk("wptr_63", 64'({cap1[1].dwr, cap1[1].daddr}), 64'({1'b1, 6'd63}));
    end
    chk("wrap_load_addr", 64'({cap1[1].dwr, cap1[1].daddr}), 64'({1'b1, 6'd0}));
    chk("wrap_mac_seq", 64'({cap1[2].daddr, cap1[3].daddr, cap1[4].daddr}), 64'({6'd0, 6'd63, 6'd62}));
    chk("wrap_dut2_seq", 64'({cap2[2].daddr, cap2[3].daddr}), 64'({6'd0, 6'd7}));

    // Requests while busy are rejected without disturbing the sequence
    capture(100, 30, 50, -1, 1'b0);
    chk("sdrop_at30",   64'(cap1[30].sdrop), 64'(1));
    chk("sdrop_count",  64'(cnt(1, 5, 1, 100)), 64'(1));
    chk("cerr_at50",    64'({cap1[50].cerr, cap1[50].cwe}), 64'(2'b10));
    chk("cerr_count",   64'(cnt(1, 6, 1, 100)), 64'(1));
    chk("cwe_busy",     64'(cnt(1, 7, 1, 100)), 64'(0));
    chk("busy_dout95",  64'(cap1[95].dout), 64'(1));
    chk("busy_dout_n",  64'(cnt(1, 4, 1, 100)), 64'(1));
    chk("busy_mul_n",   64'(cnt(1, 0, 1, 100)), 64'(64));

    // cload together with valid_in in IDLE
    capture(100, -1, -1, -1, 1'b1);
    chk("cload_same_cycle", 64'({cap1[0].cwe, cap1[0].caddr, cap1[0].cerr}), 64'({1'b1, 6'd17, 1'b0}));
    chk("cload_after", 64'({cap1[1].cwe, cap1[1].dwr, cap1[1].daddr}), 64'({1'b0, 1'b1, 6'd2}));
    chk("cload_mac_seq", 64'({cap1[2].daddr, cap1[3].daddr, cap1[4].daddr, cap1[5].daddr}),
        64'({6'd2, 6'd1, 6'd0, 6'd63}));
    chk("cload_dout95", 64'({cap1[94].dout, cap1[95].dout, cap1[96].dout}), 64'(3'b010));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
